// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline.
// Fetch-side state encoding and the IF/ID bundle live here.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
  } if_id_t;

  function automatic logic [31:0] pc_plus4(
    input logic [31:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response channel.
// master = fetch stage, slave = memory.
interface fetch_stage_if;

  logic        ImemReq;
  logic [31:0] ImemAddr;
  logic        ImemReady;
  logic        ImemValid;
  logic [31:0] ImemRData;

  modport master (
    output ImemReq,
    output ImemAddr,
    input  ImemReady,
    input  ImemValid,
    input  ImemRData
  );

  modport slave (
    input  ImemReq,
    input  ImemAddr,
    output ImemReady,
    output ImemValid,
    output ImemRData
  );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry parking register for a word that returns
// while decode is stalled.
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        unload,
  input  logic        clear,
  input  logic [31:0] din,
  output logic [31:0] word,
  output logic        full
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word <= NOP_INSTR;
      full <= 1'b0;
    end else if (clear || unload) begin
      full <= 1'b0;
    end else if (load) begin
      word <= din;
      full <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage + IF/ID register, one outstanding imem request.
// Optional perf counters: define FETCH_PERF_CNT_EN.
module fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          StallD,
  input  logic          PCSrcD,
  input  logic [31:0]   PCBranchD,
  fetch_stage_if.master imem,
  output logic [31:0]   InstrD,
  output logic [31:0]   PCPlus4D,
  output logic          ValidD
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   BubbleCntF,
  output logic [31:0]   RedirectCntF
`endif
);

  fetch_state_t state;
  fetch_state_t state_nxt;
  logic [31:0]  pcf;
  if_id_t       ifid;

  logic         hs;
  logic         redirect;
  logic         rsp;
  logic         deliver;
  logic [31:0]  deliver_word;
  logic         skid_load;
  logic         skid_unload;
  logic         skid_clear;
  logic [31:0]  skid_word;
  logic         skid_full;

  assign hs       = (state == REQ) && imem.ImemReady;
  assign redirect = PCSrcD && !StallD;
  assign rsp      = imem.ImemValid;

  assign imem.ImemReq  = (state == REQ);
  assign imem.ImemAddr = pcf;

  assign InstrD   = ifid.instr;
  assign PCPlus4D = ifid.pc4;
  assign ValidD   = ifid.valid;

  fetch_skid_buf u_skid (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (skid_load),
    .unload (skid_unload),
    .clear  (skid_clear),
    .din    (imem.ImemRData),
    .word   (skid_word),
    .full   (skid_full)
  );

  always_comb begin
    state_nxt    = state;
    deliver      = 1'b0;
    deliver_word = imem.ImemRData;
    skid_load    = 1'b0;
    skid_unload  = 1'b0;
    skid_clear   = 1'b0;
    unique case (state)
      IDLE: state_nxt = REQ;
      REQ: begin
        if (hs)
          state_nxt = redirect ? DROP : WAIT;
      end
      WAIT: begin
        if (rsp) begin
          if (redirect) begin
            state_nxt = REQ;
          end else if (StallD) begin
            skid_load = 1'b1;
            state_nxt = HOLD;
          end else begin
            deliver   = 1'b1;
            state_nxt = REQ;
          end
        end else if (redirect) begin
          state_nxt = DROP;
        end
      end
      HOLD: begin
        if (redirect) begin
          skid_clear = 1'b1;
          state_nxt  = REQ;
        end else if (!StallD && skid_full) begin
          deliver      = 1'b1;
          deliver_word = skid_word;
          skid_unload  = 1'b1;
          state_nxt    = REQ;
        end
      end
      // response of a squashed request is swallowed here
      DROP: begin
        if (rsp)
          state_nxt = REQ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      pcf   <= RESET_PC;
      ifid  <= '{instr: NOP_INSTR,
                 pc4: 32'h0,
                 valid: 1'b0};
    end else begin
      state <= state_nxt;
      if (redirect)
        pcf <= PCBranchD;
      else if (deliver)
        pcf <= pc_plus4(pcf);
      if (deliver) begin
        ifid <= '{instr: deliver_word,
                  pc4: pc_plus4(pcf),
                  valid: 1'b1};
      end else if (!StallD) begin
        ifid.instr <= NOP_INSTR;
        ifid.valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic bubble;

  assign bubble = !StallD && !deliver;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      BubbleCntF   <= 32'h0;
      RedirectCntF <= 32'h0;
    end else begin
      if (bubble && (BubbleCntF != 32'hFFFF_FFFF))
        BubbleCntF <= BubbleCntF + 32'd1;
      if (redirect && (RedirectCntF != 32'hFFFF_FFFF))
        RedirectCntF <= RedirectCntF + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random
// stall/redirect/ready traffic against a PC-stream model.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        StallD = 1'b0;
  logic        PCSrcD = 1'b0;
  logic [31:0] PCBranchD = 32'h0;
  logic [31:0] InstrD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] BubbleCntF;
  logic [31:0] RedirectCntF;
`endif

  fetch_stage_if imem ();

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .StallD    (StallD),
    .PCSrcD    (PCSrcD),
    .PCBranchD (PCBranchD),
    .imem      (imem),
    .InstrD    (InstrD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
`ifdef FETCH_PERF_CNT_EN
    ,
    .BubbleCntF   (BubbleCntF),
    .RedirectCntF (RedirectCntF)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int kfix = 1;
  int n_deliv = 0;
  int n_hs = 0;

  logic        mem_busy = 1'b0;
  int          mem_due = 0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] exp_pc = RST_PC;

  logic        last_req;
  logic        last_hs;
  logic [31:0] last_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h5A1F};
  endfunction

  // one clock: drive at negedge, sample request #1 later,
  // then check IF/ID #1 after the rising edge
  task automatic cycle(input logic st, input logic br,
                       input logic [31:0] tgt, input logic rdy);
    logic vld;
    logic hon;
    logic [31:0] i_old;
    logic [31:0] p_old;
    logic v_old;
    @(negedge clk);
    rst_n = 1'b1;
    StallD = st;
    PCSrcD = br;
    PCBranchD = tgt;
    imem.ImemReady = rdy;
    vld = mem_busy && (cyc == mem_due);
    imem.ImemValid = vld;
    imem.ImemRData = vld ? mem_word(mem_addr) : $urandom;
    #1;
    last_req = imem.ImemReq;
    last_addr = imem.ImemAddr;
    last_hs = last_req && rdy;
    i_old = InstrD;
    p_old = PCPlus4D;
    v_old = ValidD;
    hon = br && !st;
    if (last_hs) begin
      n_hs++;
      n_cmp++;
      if (mem_busy) begin
        n_err++;
        $display("FAIL one_outstanding: handshake at %h got busy=1 want 0",
                 last_addr);
      end
      if (!hon) begin
        n_cmp++;
        if (last_addr !== exp_pc) begin
          n_err++;
          $display("FAIL req_addr: got %h want %h", last_addr, exp_pc);
        end
      end
    end
    @(posedge clk);
    #1;
    if (vld) mem_busy = 1'b0;
    if (last_hs) begin
      mem_busy = 1'b1;
      mem_addr = last_addr;
      mem_due = cyc + ((kfix != 0) ? kfix : int'($urandom_range(3, 1)));
    end
    cyc++;
    if (st) begin
      n_cmp++;
      if (InstrD !== i_old || PCPlus4D !== p_old || ValidD !== v_old) begin
        n_err++;
        $display("FAIL stall_hold: got %h/%h/%b want %h/%h/%b",
                 InstrD, PCPlus4D, ValidD, i_old, p_old, v_old);
      end
    end else if (hon) begin
      n_cmp++;
      if (InstrD !== 32'h0 || ValidD !== 1'b0 || PCPlus4D !== p_old) begin
        n_err++;
        $display("FAIL redirect_bubble: got %h/%h/%b want 0/%h/0",
                 InstrD, PCPlus4D, ValidD, p_old);
      end
      exp_pc = tgt;
    end else if (ValidD === 1'b1) begin
      n_cmp++;
      if (InstrD !== mem_word(exp_pc) || PCPlus4D !== exp_pc + 32'd4) begin
        n_err++;
        $display("FAIL deliver: got %h/%h want %h/%h",
                 InstrD, PCPlus4D, mem_word(exp_pc), exp_pc + 32'd4);
      end
      exp_pc = exp_pc + 32'd4;
      n_deliv++;
    end else begin
      n_cmp++;
      if (InstrD !== 32'h0 || PCPlus4D !== p_old || ValidD !== 1'b0) begin
        n_err++;
        $display("FAIL bubble: got %h/%h/%b want 0/%h/0",
                 InstrD, PCPlus4D, ValidD, p_old);
      end
    end
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      StallD = 1'($urandom);
      PCSrcD = 1'($urandom);
      PCBranchD = $urandom;
      imem.ImemReady = 1'($urandom);
      imem.ImemValid = 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      n_cmp++;
      if ({InstrD, PCPlus4D, ValidD} !== 65'b0) begin
        n_err++;
        $display("FAIL reset_ifid: got %h/%h/%b want 0/0/0",
                 InstrD, PCPlus4D, ValidD);
      end
      n_cmp++;
      if (imem.ImemReq !== 1'b0 || imem.ImemAddr !== RST_PC) begin
        n_err++;
        $display("FAIL reset_req: got %b/%h want 0/%h",
                 imem.ImemReq, imem.ImemAddr, RST_PC);
      end
    end
    mem_busy = 1'b0;
    exp_pc = RST_PC;
  endtask

  task automatic test_reset;
    logic [3:0] vseq;
    kfix = 1;
    do_reset(2);
    cycle(0, 0, 32'h0, 1);
    n_cmp++;
    if (last_req !== 1'b0) begin
      n_err++;
      $display("FAIL idle_req: got %b want 0", last_req);
    end
    cycle(0, 0, 32'h0, 1);
    vseq[0] = ValidD;
    n_cmp++;
    if (last_hs !== 1'b1 || last_addr !== 32'h100) begin
      n_err++;
      $display("FAIL first_addr: got %b/%h want 1/100", last_hs, last_addr);
    end
    cycle(0, 0, 32'h0, 1);
    vseq[1] = ValidD;
    n_cmp++;
    if (PCPlus4D !== 32'h104) begin
      n_err++;
      $display("FAIL first_pc4: got %h want 104", PCPlus4D);
    end
    cycle(0, 0, 32'h0, 1);
    vseq[2] = ValidD;
    n_cmp++;
    if (last_addr !== 32'h104 || last_req !== 1'b1) begin
      n_err++;
      $display("FAIL second_addr: got %b/%h want 1/104", last_req, last_addr);
    end
    cycle(0, 0, 32'h0, 1);
    vseq[3] = ValidD;
    n_cmp++;
    if (PCPlus4D !== 32'h108) begin
      n_err++;
      $display("FAIL second_pc4: got %h want 108", PCPlus4D);
    end
    n_cmp++;
    if (vseq !== 4'b1010) begin
      n_err++;
      $display("FAIL valid_seq: got %b want 1010", vseq);
    end
    cycle(0, 0, 32'h0, 1);
    n_cmp++;
    if (last_addr !== 32'h108 || last_hs !== 1'b1) begin
      n_err++;
      $display("FAIL third_addr: got %b/%h want 1/108", last_hs, last_addr);
    end
  endtask

  task automatic test_stall;
    int reqs;
    reqs = 0;
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 32'h0, 1);
      reqs += int'(last_req);
      n_cmp++;
      if (InstrD !== 32'h0 || PCPlus4D !== 32'h108) begin
        n_err++;
        $display("FAIL stall_ifid: got %h/%h want 0/108", InstrD, PCPlus4D);
      end
    end
    n_cmp++;
    if (reqs != 0) begin
      n_err++;
      $display("FAIL stall_noreq: got %0d want 0", reqs);
    end
    cycle(0, 0, 32'h0, 1);
    n_cmp++;
    if (InstrD !== mem_word(32'h108) || PCPlus4D !== 32'h10C
        || ValidD !== 1'b1) begin
      n_err++;
      $display("FAIL skid_deliver: got %h/%h/%b want %h/10c/1",
               InstrD, PCPlus4D, ValidD, mem_word(32'h108));
    end
  endtask

  task automatic test_redirect_hs;
    cycle(0, 1, 32'h200, 1);
    n_cmp++;
    if (last_hs !== 1'b1 || last_addr !== 32'h10C) begin
      n_err++;
      $display("FAIL redir_hs: got %b/%h want 1/10c", last_hs, last_addr);
    end
    cycle(0, 0, 32'h0, 1);
    n_cmp++;
    if (last_req !== 1'b0 || ValidD !== 1'b0) begin
      n_err++;
      $display("FAIL drop: got req=%b valid=%b want 0/0", last_req, ValidD);
    end
    cycle(0, 0, 32'h0, 1);
    n_cmp++;
    if (last_req !== 1'b1 || last_addr !== 32'h200) begin
      n_err++;
      $display("FAIL redir_addr: got %b/%h want 1/200", last_req, last_addr);
    end
    cycle(0, 0, 32'h0, 1);
    n_cmp++;
    if (InstrD !== mem_word(32'h200) || PCPlus4D !== 32'h204) begin
      n_err++;
      $display("FAIL redir_deliver: got %h/%h want %h/204",
               InstrD, PCPlus4D, mem_word(32'h200));
    end
  endtask

  task automatic test_redirect_stalled;
    cycle(1, 1, 32'h400, 1);
    n_cmp++;
    if (InstrD !== mem_word(32'h200) || ValidD !== 1'b1) begin
      n_err++;
      $display("FAIL stalled_redir_hold: got %h/%b want %h/1",
               InstrD, ValidD, mem_word(32'h200));
    end
    cycle(0, 0, 32'h0, 1);
    n_cmp++;
    if (InstrD !== mem_word(32'h204) || PCPlus4D !== 32'h208) begin
      n_err++;
      $display("FAIL stalled_redir_pc: got %h/%h want %h/208",
               InstrD, PCPlus4D, mem_word(32'h204));
    end
  endtask

  task automatic test_not_ready;
    int hs0;
    hs0 = n_hs;
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 32'h0, 0);
      n_cmp++;
      if (last_req !== 1'b1 || last_addr !== 32'h208) begin
        n_err++;
        $display("FAIL nr_req: got %b/%h want 1/208", last_req, last_addr);
      end
    end
    cycle(0, 1, 32'h300, 0);
    cycle(0, 0, 32'h0, 1);
    n_cmp++;
    if (last_req !== 1'b1 || last_addr !== 32'h300) begin
      n_err++;
      $display("FAIL nr_addr: got %b/%h want 1/300", last_req, last_addr);
    end
    cycle(0, 0, 32'h0, 1);
    n_cmp++;
    if (n_hs - hs0 != 1) begin
      n_err++;
      $display("FAIL nr_accepts: got %0d want 1", n_hs - hs0);
    end
    n_cmp++;
    if (InstrD !== mem_word(32'h300) || PCPlus4D !== 32'h304) begin
      n_err++;
      $display("FAIL nr_deliver: got %h/%h want %h/304",
               InstrD, PCPlus4D, mem_word(32'h300));
    end
  endtask

  task automatic test_wrap_and_reset;
    cycle(0, 1, 32'hFFFF_FFFC, 0);
    cycle(0, 0, 32'h0, 1);
    cycle(0, 0, 32'h0, 1);
    n_cmp++;
    if (PCPlus4D !== 32'h0 || InstrD !== mem_word(32'hFFFF_FFFC)) begin
      n_err++;
      $display("FAIL wrap_pc4: got %h/%h want 0/%h",
               PCPlus4D, InstrD, mem_word(32'hFFFF_FFFC));
    end
    kfix = 2;
    cycle(0, 0, 32'h0, 1);
    n_cmp++;
    if (last_hs !== 1'b1 || last_addr !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_addr: got %b/%h want 1/0", last_hs, last_addr);
    end
    do_reset(1);
    kfix = 1;
    cycle(0, 0, 32'h0, 1);
    n_cmp++;
    if (last_req !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: got %b want 0", last_req);
    end
    cycle(0, 0, 32'h0, 1);
    n_cmp++;
    if (last_addr !== 32'h100) begin
      n_err++;
      $display("FAIL post_reset_addr: got %h want 100", last_addr);
    end
    cycle(0, 0, 32'h0, 1);
    n_cmp++;
    if (InstrD !== mem_word(32'h100) || ValidD !== 1'b1) begin
      n_err++;
      $display("FAIL post_reset_deliver: got %h/%b want %h/1",
               InstrD, ValidD, mem_word(32'h100));
    end
  endtask

  task automatic test_random;
    int d0;
    do_reset(1);
    kfix = 0;
    d0 = n_deliv;
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(3, 0) == 0),
            1'($urandom_range(9, 0) == 0),
            $urandom & 32'hFFFF_FFFC,
            1'($urandom_range(9, 0) < 7));
    end
    n_cmp++;
    if (n_deliv - d0 < 40) begin
      n_err++;
      $display("FAIL rand_progress: got %0d deliveries want >=40",
               n_deliv - d0);
    end
  endtask

  initial begin
    imem.ImemReady = 1'b0;
    imem.ImemValid = 1'b0;
    imem.ImemRData = 32'h0;
    test_reset();
    test_stall();
    test_redirect_hs();
    test_redirect_stalled();
    test_not_ready();
    test_wrap_and_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
